// File: rtl/half_adder_pkg.sv
// Shared constants and types for the registered lane-parallel half adder.
package half_adder_pkg;
  localparam int HA_DEFAULT_WIDTH = 1;
  localparam int HA_MAX_PIPE      = 4;
  localparam int HA_CNT_W         = 16;

  typedef logic [HA_CNT_W-1:0] ha_count_t;
endpackage

// File: rtl/half_adder_if.sv
// Valid-qualified operand/result bundle for half_adder; slave is the adder side.
interface half_adder_if
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_DEFAULT_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;

  modport master (
    output in_valid, a, b,
    input  out_valid, sum, carry
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, sum, carry
  );
endinterface

// File: rtl/half_adder_cell.sv
// Purely combinational 1-bit half adder cell.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/half_adder.sv
// Registered lane-parallel half adder with a valid-qualified pipeline of PIPE_STAGES.
// Optional carry popcount accumulator enabled by HALF_ADDER_CARRY_COUNT_EN.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH       = HA_DEFAULT_WIDTH,
  parameter int PIPE_STAGES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  half_adder_if.slave  bus
`ifdef HALF_ADDER_CARRY_COUNT_EN
  ,
  output ha_count_t    carry_count
`endif
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a     (bus.a[i]),
      .b     (bus.b[i]),
      .sum   (sum_c[i]),
      .carry (carry_c[i])
    );
  end

  logic [WIDTH-1:0] sum_p   [PIPE_STAGES];
  logic [WIDTH-1:0] carry_p [PIPE_STAGES];
  logic             vld_p   [PIPE_STAGES];

  // Stage 0 captures the cell outputs; later stages shift forward only on valid,
  // so the last stage holds the most recent result through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        vld_p[s]   <= 1'b0;
        sum_p[s]   <= '0;
        carry_p[s] <= '0;
      end
    end else begin
      vld_p[0] <= bus.in_valid;
      if (bus.in_valid) begin
        sum_p[0]   <= sum_c;
        carry_p[0] <= carry_c;
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        vld_p[s] <= vld_p[s-1];
        if (vld_p[s-1]) begin
          sum_p[s]   <= sum_p[s-1];
          carry_p[s] <= carry_p[s-1];
        end
      end
    end
  end

  assign bus.out_valid = vld_p[PIPE_STAGES-1];
  assign bus.sum       = sum_p[PIPE_STAGES-1];
  assign bus.carry     = carry_p[PIPE_STAGES-1];

`ifdef HALF_ADDER_CARRY_COUNT_EN
  logic             last_vld;
  logic [WIDTH-1:0] last_carry;

  // The counter samples what the final stage is about to load, so it moves with out_valid.
  if (PIPE_STAGES == 1) begin : g_last_in
    assign last_vld   = bus.in_valid;
    assign last_carry = carry_c;
  end else begin : g_last_in
    assign last_vld   = vld_p[PIPE_STAGES-2];
    assign last_carry = carry_p[PIPE_STAGES-2];
  end

  function automatic logic [6:0] popcount(input logic [WIDTH-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + 7'(v[i]);
    return n;
  endfunction

  function automatic ha_count_t sat_add(input ha_count_t acc, input logic [6:0] inc);
    logic [HA_CNT_W:0] total;
    total = {1'b0, acc} + {{(HA_CNT_W-6){1'b0}}, inc};
    return total[HA_CNT_W] ? '1 : total[HA_CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_count <= '0;
    end else if (last_vld) begin
      carry_count <= sat_add(carry_count, popcount(last_carry));
    end
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: three configurations share clock and reset.
module tb_half_adder;
  import half_adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  half_adder_if #(.WIDTH(8))  ia ();
  half_adder_if #(.WIDTH(64)) ib ();
  half_adder_if #(.WIDTH(1))  ic ();

`ifdef HALF_ADDER_CARRY_COUNT_EN
  ha_count_t cnt_a, cnt_b, cnt_c;
`endif

  half_adder #(.WIDTH(8), .PIPE_STAGES(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
`ifdef HALF_ADDER_CARRY_COUNT_EN
    , .carry_count(cnt_a)
`endif
  );
  half_adder #(.WIDTH(64), .PIPE_STAGES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
`ifdef HALF_ADDER_CARRY_COUNT_EN
    , .carry_count(cnt_b)
`endif
  );
  half_adder #(.WIDTH(1), .PIPE_STAGES(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ic)
`ifdef HALF_ADDER_CARRY_COUNT_EN
    , .carry_count(cnt_c)
`endif
  );

  typedef struct {
    logic [63:0] s;
    logic [63:0] c;
    int          t;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int n_chk = 0, n_fail = 0, cyc = 0, cnt_m = 0;
  logic [63:0] la_s, la_c, lb_s, lb_c, lc_s, lc_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: per lane, the two operand bits are added as integers; the result's
  // low digit is the sum, the high digit the carry.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int w, input int t);
    exp_t e;
    e.s = '0; e.c = '0; e.t = t;
    for (int i = 0; i < w; i++) begin
      int tot;
      tot = int'(a[i]) + int'(b[i]);
      e.s[i] = (tot % 2) == 1;
      e.c[i] = (tot / 2) == 1;
    end
    return e;
  endfunction

  task automatic put_a(input logic v, input logic [7:0] a, input logic [7:0] b);
    ia.in_valid = v; ia.a = a; ia.b = b;
    if (v) qa.push_back(model(64'(a), 64'(b), 8, cyc));
  endtask
  task automatic put_b(input logic v, input logic [63:0] a, input logic [63:0] b);
    ib.in_valid = v; ib.a = a; ib.b = b;
    if (v) qb.push_back(model(a, b, 64, cyc));
  endtask
  task automatic put_c(input logic v, input logic a, input logic b);
    ic.in_valid = v; ic.a = a; ic.b = b;
    if (v) qc.push_back(model(64'(a), 64'(b), 1, cyc));
  endtask

  task automatic cycle(input logic va, input logic [7:0] aa, input logic [7:0] ba,
                       input logic vb, input logic [63:0] ab, input logic [63:0] bb,
                       input logic vc, input logic ac, input logic bc);
    @(negedge clk);
    put_a(va, aa, ba);
    put_b(vb, ab, bb);
    put_c(vc, ac, bc);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic flush();
    qa.delete(); qb.delete(); qc.delete();
    la_s = 0; la_c = 0; lb_s = 0; lb_c = 0; lc_s = 0; lc_c = 0;
    cnt_m = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_out_valid"}, 64'(ia.out_valid), 0);
    chk({tag, "_a_sum"}, 64'(ia.sum), 0);
    chk({tag, "_a_carry"}, 64'(ia.carry), 0);
    chk({tag, "_b_out_valid"}, 64'(ib.out_valid), 0);
    chk({tag, "_b_sum"}, ib.sum, 0);
    chk({tag, "_b_carry"}, ib.carry, 0);
    chk({tag, "_c_out_valid"}, 64'(ic.out_valid), 0);
    chk({tag, "_c_sum"}, 64'(ic.sum), 0);
    chk({tag, "_c_carry"}, 64'(ic.carry), 0);
`ifdef HALF_ADDER_CARRY_COUNT_EN
    chk({tag, "_a_carry_count"}, 64'(cnt_a), 0);
`endif
  endtask

  // Asynchronous reset pulse between clock edges, released on a falling edge.
  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #2;
    put_a(0, 0, 0); put_b(0, 0, 0); put_c(0, 0, 0);
    rst_n = 1'b0;
    flush();
    #1;
    check_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ia.out_valid) begin
        chk("a_result_pending", 64'(qa.size() != 0), 1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          chk("a_sum", 64'(ia.sum), ea.s);
          chk("a_carry", 64'(ia.carry), ea.c);
          chk("a_latency", 64'(cyc), 64'(ea.t + 3));
          la_s = ea.s; la_c = ea.c;
          cnt_m = cnt_m + $countones(ea.c);
          if (cnt_m > 65535) cnt_m = 65535;
        end
      end else begin
        chk("a_hold_sum", 64'(ia.sum), la_s);
        chk("a_hold_carry", 64'(ia.carry), la_c);
      end
`ifdef HALF_ADDER_CARRY_COUNT_EN
      chk("a_carry_count_model", 64'(cnt_a), 64'(cnt_m));
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ib.out_valid) begin
        chk("b_result_pending", 64'(qb.size() != 0), 1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          chk("b_sum", ib.sum, eb.s);
          chk("b_carry", ib.carry, eb.c);
          chk("b_latency", 64'(cyc), 64'(eb.t + 1));
          lb_s = eb.s; lb_c = eb.c;
        end
      end else begin
        chk("b_hold_sum", ib.sum, lb_s);
        chk("b_hold_carry", ib.carry, lb_c);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ic.out_valid) begin
        chk("c_result_pending", 64'(qc.size() != 0), 1);
        if (qc.size() != 0) begin
          ec = qc.pop_front();
          chk("c_sum", 64'(ic.sum), ec.s);
          chk("c_carry", 64'(ic.carry), ec.c);
          chk("c_latency", 64'(cyc), 64'(ec.t + 1));
          lc_s = ec.s; lc_c = ec.c;
        end
      end else begin
        chk("c_hold_sum", 64'(ic.sum), lc_s);
        chk("c_hold_carry", 64'(ic.carry), lc_c);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    put_a(0, 0, 0); put_b(0, 0, 0); put_c(0, 0, 0);
    flush();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Single-lane truth table, back to back.
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(4);

    // Eight lanes through three stages, then a bubble pattern.
    cycle(1, 8'hF0, 8'h3C, 0, 0, 0, 0, 0, 0);
    idle(5);
    cycle(1, 8'h01, 8'h01, 0, 0, 0, 0, 0, 0);
    idle(1);
    cycle(1, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0);
    idle(5);

    // 64-lane extremes.
    cycle(0, 0, 0, 1, '1, '1, 0, 0, 0);
    cycle(0, 0, 0, 1, '1, '0, 0, 0, 0);
    idle(3);

    // Two samples in flight when reset hits; nothing may emerge afterwards.
    cycle(1, 8'h5A, 8'hFF, 1, 64'h1234, 64'hFFFF, 0, 0, 0);
    cycle(1, 8'hC3, 8'h0F, 0, 0, 0, 0, 0, 0);
    reset_pulse("midflight");
    idle(6);
    cycle(1, 8'hAA, 8'h55, 0, 0, 0, 0, 0, 0);
    idle(5);

    repeat (400)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(5);

`ifdef HALF_ADDER_CARRY_COUNT_EN
    reset_pulse("count_clear");
    repeat (10) cycle(1, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0);
    idle(5);
    chk("carry_count_after_10", 64'(cnt_a), 80);
    repeat (8200) cycle(1, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0);
    idle(5);
    chk("carry_count_saturated", 64'(cnt_a), 64'hFFFF);
    reset_pulse("count_reset");
    idle(2);
`endif

    chk("a_drained", 64'(qa.size()), 0);
    chk("b_drained", 64'(qb.size()), 0);
    chk("c_drained", 64'(qc.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
